// File: rtl/id_stage.sv
// RV32I decode stage: operand fetch with WB bypass, immediate and control
// generation, load-use detection, and the ID/EX pipeline register.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_flush,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic [6:0]  ex_opcode,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_alu_src
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
    } ctrl_t;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    ctrl_t       ctrl;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        hazard;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_val_q;
    logic [31:0] rs2_val_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q;
    logic [6:0]  opcode_q;
    ctrl_t       ctrl_q;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    always_comb begin
        imm      = '0;
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (opcode)
            OP_LOAD: begin
                imm  = {{20{if_instr[31]}}, if_instr[31:20]};
                ctrl = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b0, alu_src: 1'b1};
                uses_rs1 = 1'b1;
            end
            OP_IMM: begin
                imm  = {{20{if_instr[31]}}, if_instr[31:20]};
                ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b0, alu_src: 1'b1};
                uses_rs1 = 1'b1;
            end
            OP_JALR: begin
                imm  = {{20{if_instr[31]}}, if_instr[31:20]};
                ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b1, alu_src: 1'b1};
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                imm  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                ctrl = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1,
                         branch: 1'b0, jump: 1'b0, alu_src: 1'b1};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm  = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                        if_instr[30:25], if_instr[11:8], 1'b0};
                ctrl = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b1, jump: 1'b0, alu_src: 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm  = {if_instr[31:12], 12'b0};
                ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b0, alu_src: 1'b1};
            end
            OP_JAL: begin
                imm  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                        if_instr[20], if_instr[30:21], 1'b0};
                ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b1, alu_src: 1'b1};
            end
            OP_REG: begin
                ctrl = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                         branch: 1'b0, jump: 1'b0, alu_src: 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: begin
                // Unknown opcodes still read rs1 so hazard checks stay conservative
                uses_rs1 = 1'b1;
            end
        endcase
    end

    // Regfile writes land at the edge, so a same-cycle read sees the old value
    assign rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rd1;
    assign rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rd2;

    assign hazard = if_valid && valid_q && ctrl_q.mem_read && rd_q != 5'd0 &&
                    ((uses_rs1 && rd_q == rs1) || (uses_rs2 && rd_q == rs2));
    assign stall  = hazard && !ex_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            opcode_q   <= '0;
            ctrl_q     <= '0;
        end else if (ex_flush || hazard) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q    <= if_valid;
            pc_q       <= if_pc;
            rs1_val_q  <= rs1_val;
            rs2_val_q  <= rs2_val;
            imm_q      <= imm;
            rs1_q      <= rs1;
            rs2_q      <= rs2;
            rd_q       <= rd;
            funct3_q   <= if_instr[14:12];
            funct7b5_q <= if_instr[30];
            opcode_q   <= opcode;
            ctrl_q     <= if_valid ? ctrl : '0;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_val   = rs1_val_q;
    assign ex_rs2_val   = rs2_val_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_funct3    = funct3_q;
    assign ex_funct7b5  = funct7b5_q;
    assign ex_opcode    = opcode_q;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jump      = ctrl_q.jump;
    assign ex_alu_src   = ctrl_q.alu_src;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use stall, flush,
// immediates and reset behaviour.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [6:0]  ex_opcode;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_alu_src;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] ADDI   = 32'hFFD08293;
    localparam logic [31:0] ADD3   = 32'h002081B3;
    localparam logic [31:0] LW4    = 32'h0000A203;
    localparam logic [31:0] ADD6   = 32'h00720333;
    localparam logic [31:0] LUI4   = 32'h12345237;
    localparam logic [31:0] BEQ    = 32'hFE000EE3;
    localparam logic [31:0] JAL    = 32'h001000EF;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1),
        .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_opcode(ex_opcode), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'($urandom);
        if_instr = $urandom;
        if_pc    = $urandom;
        rf_rd1   = $urandom;
        rf_rd2   = $urandom;
        wb_we    = 1'($urandom);
        wb_rd    = 5'($urandom);
        wb_data  = $urandom;
        ex_flush = 1'($urandom);
        tick();
        if_instr = $urandom;
        rf_rd1   = $urandom;
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rs1_val", ex_rs1_val, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_opcode", 32'(ex_opcode), 32'd0);
        chk("rst_ctrl", {26'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_branch, ex_jump, ex_alu_src}, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        rst_n    = 1'b1;
        ex_flush = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = 5'd0;
        issue(ADDI, 32'h0000_0100);
        rf_rd1 = 32'd10;
        rf_rd2 = 32'd0;
        #1;
        chk("addi_a1", 32'(rf_a1), 32'd1);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFD);
        chk("addi_rs1_val", ex_rs1_val, 32'd10);
        chk("addi_rd", 32'(ex_rd), 32'd5);
        chk("addi_pc", ex_pc, 32'h0000_0100);
        chk("addi_regw", 32'(ex_reg_write), 32'd1);
        chk("addi_alusrc", 32'(ex_alu_src), 32'd1);

        issue(ADD3, 32'h0000_0104);
        rf_rd1  = 32'd1;
        rf_rd2  = 32'd2;
        wb_we   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 32'h55;
        tick();
        chk("byp_rs2_val", ex_rs2_val, 32'h55);
        chk("byp_rs1_val", ex_rs1_val, 32'd1);
        chk("add_alusrc", 32'(ex_alu_src), 32'd0);
        chk("add_rd", 32'(ex_rd), 32'd3);

        wb_rd = 5'd0;
        tick();
        chk("x0_nobyp_rs2", ex_rs2_val, 32'd2);
        wb_we = 1'b0;

        issue(LW4, 32'h0000_0200);
        rf_rd1 = 32'h1000;
        tick();
        chk("lw_memrd", 32'(ex_mem_read), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd4);
        issue(ADD6, 32'h0000_0204);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_regw", 32'(ex_reg_write), 32'd0);
        chk("lu_stall_clear", 32'(stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rs1", 32'(ex_rs1), 32'd4);
        chk("lu_add_rd", 32'(ex_rd), 32'd6);
        chk("lu_add_pc", ex_pc, 32'h0000_0204);

        issue(LW4, 32'h0000_0300);
        tick();
        issue(LUI4, 32'h0000_0304);
        #1;
        chk("lui_nostall", 32'(stall), 32'd0);
        tick();
        chk("lui_valid", 32'(ex_valid), 32'd1);
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_rd", 32'(ex_rd), 32'd4);

        issue(LW4, 32'h0000_0400);
        tick();
        issue(ADD6, 32'h0000_0404);
        ex_flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_ctrl", {26'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                           ex_branch, ex_jump, ex_alu_src}, 32'd0);
        ex_flush = 1'b0;

        issue(BEQ, 32'h0000_0500);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_branch", 32'(ex_branch), 32'd1);
        chk("beq_alusrc", 32'(ex_alu_src), 32'd0);
        chk("beq_regw", 32'(ex_reg_write), 32'd0);

        issue(JAL, 32'h0000_0504);
        tick();
        chk("jal_imm", ex_imm, 32'h0000_0800);
        chk("jal_jump", 32'(ex_jump), 32'd1);
        chk("jal_regw", 32'(ex_reg_write), 32'd1);

        issue(32'h0000_0000, 32'h0000_0508);
        tick();
        chk("unk_valid", 32'(ex_valid), 32'd1);
        chk("unk_ctrl", {26'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                         ex_branch, ex_jump, ex_alu_src}, 32'd0);

        issue(ADDI, 32'h0000_0600);
        if_valid = 1'b0;
        tick();
        chk("inv_valid", 32'(ex_valid), 32'd0);
        chk("inv_regw", 32'(ex_reg_write), 32'd0);

        issue(LW4, 32'h0000_0700);
        tick();
        issue(ADD6, 32'h0000_0704);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", 32'(stall), 32'd1);
        tick();
        chk("rstmid_valid", 32'(ex_valid), 32'd0);
        chk("rstmid_stall_drop", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the 5-stage RV32I pipeline, sitting between the IF/ID register and the execute stage. It drives the register-file read addresses, forms operand values with a writeback-to-decode bypass, and generates the immediate and control bits. It also detects load-use hazards and owns the ID/EX pipeline register, including stall-bubble and flush handling.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction from IF/ID
- if_pc  in  32  PC of if_instr
- rf_a1, rf_a2  out  5 each  register-file read addresses; combinational, = if_instr[19:15], [24:20]
- rf_rd1, rf_rd2  in  32 each  register-file read data; combinational, x0 reads 0
- wb_we  in  1  writeback write enable, same cycle as the regfile write
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- ex_flush  in  1  taken branch/jump resolved in EX; kill ID
- stall  out  1  combinational; 1 = IF and IF/ID must hold
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  registered operands and immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
- ex_funct3  out  3  registered instr[14:12]
- ex_funct7b5  out  1  registered instr[30]
- ex_opcode  out  7  registered instr[6:0]
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src  out  1 each  registered control

## Operation
- Immediates, sign-extended to 32 bits, selected by opcode:
  - I-type for 0000011, 0010011, 1100111.
  - S-type for 0100011.
  - B-type for 1100011 (bit 0 = 0).
  - U-type for 0110111, 0010111 (low 12 bits 0).
  - J-type for 1101111 (bit 0 = 0).
  - 0 otherwise.
- Control:
  - reg_write = load, op-imm, R (0110011), lui, auipc, jal, jalr.
  - mem_read = load.
  - mem_write = store.
  - branch = 1100011.
  - jump = jal or jalr.
  - alu_src = 1 for every opcode except R and branch.
  - Unrecognised opcode: all control 0; ex_valid still follows the valid rules.
- Register usage: uses_rs1 = every opcode except lui, auipc, jal. uses_rs2 = R, store, branch.
- WB bypass: if wb_we && wb_rd != 0 && wb_rd == rs1, the rs1 operand is wb_data; otherwise it is rf_rd1. Same rule for rs2. Required because the register file writes at the clock edge, so a same-cycle read returns the old value.
- Load-use hazard: hazard = if_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
- stall = hazard && !ex_flush.
- ID/EX update, at each rising edge, highest priority first:
  - !rst_n: every ex_* output = 0.
  - ex_flush: ex_valid and all ex_ control bits = 0; data fields don't-care (implemented as hold).
  - stall: same bubble as flush; IF/ID is held externally, so the same instruction re-decodes next cycle.
  - otherwise: load the decoded fields; ex_valid = if_valid. When if_valid = 0, all control bits = 0.

## Timing
- Decode latency: 1 cycle. An instruction present in IF/ID at edge N appears on ex_* after edge N.
- rf_a1/rf_a2, stall, bypass and hazard logic are combinational from the IF/ID and WB inputs; no registered feedback other than ID/EX.
- A load-use pair costs exactly 1 bubble cycle. On the second decode, the load is in MEM, so the hazard clears; MEM-to-EX forwarding belongs to EX, not this block.
- ex_flush together with hazard: flush wins and stall = 0, so IF redirects.
- Reset asserted mid-stall: stall still evaluates combinationally from the current inputs, but ex_valid = 0 after the edge, so stall drops in the following cycle.
- wb_rd = 0 never bypasses; x0 always yields 0.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with random inputs -> all ex_* = 0, stall = 0.
- Decode: addi x5,x1,-3 (0xFFD08293), rf_rd1 = 10 -> next cycle ex_imm = 0xFFFFFFFD, ex_rs1_val = 10, ex_rd = 5, ex_reg_write = 1, ex_alu_src = 1.
- WB bypass: add x3,x1,x2 with rf_rd1 = 1, rf_rd2 = 2, and wb_we = 1, wb_rd = 2, wb_data = 0x55 in the same cycle -> ex_rs2_val = 0x55, ex_rs1_val = 1. Repeat with wb_rd = 0 -> ex_rs2_val = 2.
- Load-use: lw x4,0(x1) followed by add x6,x4,x7 -> stall = 1 for exactly one cycle, one bubble (ex_valid = 0), then the add issues with ex_rs1 = 4. lw followed by lui x4 -> no stall.
- Flush priority: load-use condition present plus ex_flush = 1 -> stall = 0, and next cycle ex_valid = 0 with all control 0.
- Immediates: beq x0,x0,-4 (0xFE000EE3) -> ex_imm = 0xFFFFFFFC. jal x1,+2048 (0x001000EF) -> ex_imm = 0x00000800, ex_jump = 1.
